// File: rtl/sd_moore_verilog.sv
// rtl/sd_moore_verilog.sv - Moore FSM flagging the overlapping serial pattern 1011
// Optional match counter output enabled by defining SD_MOORE_COUNT_EN.
module sd_moore_verilog (
  input  logic       clock,
  input  logic       reset,
  input  logic       sequence_in,
`ifdef SD_MOORE_COUNT_EN
  output logic [7:0] detect_count,
`endif
  output logic       detector_out
);

  localparam logic [2:0] IDLE  = 3'b000;
  localparam logic [2:0] S1    = 3'b001;
  localparam logic [2:0] S10   = 3'b010;
  localparam logic [2:0] S101  = 3'b011;
  localparam logic [2:0] MATCH = 3'b100;

  logic [2:0] state_q;
  logic [2:0] state_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // MATCH falls back to S1/S10 so the trailing 1 can start the next match
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = sequence_in ? S1    : IDLE;
      S1:      state_d = sequence_in ? S1    : S10;
      S10:     state_d = sequence_in ? S101  : IDLE;
      S101:    state_d = sequence_in ? MATCH : S10;
      MATCH:   state_d = sequence_in ? S1    : S10;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    detector_out = (state_q == MATCH);
  end

`ifdef SD_MOORE_COUNT_EN
  logic [7:0] count_q;
  logic [7:0] count_d;

  // Counts on the edge entering MATCH, so it moves together with detector_out
  always_comb begin
    count_d = count_q;
    if (state_d == MATCH) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign detect_count = count_q;
`endif

endmodule

// File: tb/tb_sd_moore_verilog.sv
// tb/tb_sd_moore_verilog.sv - scoreboard bench for sd_moore_verilog
// Honours SD_MOORE_COUNT_EN to also check detect_count.
module tb_sd_moore_verilog;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sequence_in = 1'b0;
  logic detector_out;
`ifdef SD_MOORE_COUNT_EN
  logic [7:0] detect_count;
`endif

  sd_moore_verilog dut (
    .clock(clock),
    .reset(reset),
    .sequence_in(sequence_in),
`ifdef SD_MOORE_COUNT_EN
    .detect_count(detect_count),
`endif
    .detector_out(detector_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       det;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  logic [3:0] hist = 4'd0;
  logic [7:0] mcnt = 8'd0;
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: a match is simply "last four bits since reset read 1011"
  task automatic step(input logic b);
    exp_t e;
    sequence_in = b;
    @(posedge clock);
    if (!reset) begin
      hist = 4'd0;
      mcnt = 8'd0;
      e.det = 1'b0;
      e.cnt = 8'd0;
    end else begin
      hist = {hist[2:0], b};
      e.det = (hist == 4'b1011);
      if (e.det) mcnt = mcnt + 8'd1;
      e.cnt = mcnt;
    end
    q.push_back(e);
    #2;
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(v[i]);
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2;
    reset = 1'b0;
    hist = 4'd0;
    mcnt = 8'd0;
    #1;
    check("async_rst_det", {7'd0, detector_out}, 8'd0);
`ifdef SD_MOORE_COUNT_EN
    check("async_rst_cnt", detect_count, 8'd0);
`endif
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("det", {7'd0, detector_out}, {7'd0, e.det});
`ifdef SD_MOORE_COUNT_EN
      check("cnt", detect_count, e.cnt);
`endif
    end
  end

  initial begin
    int guard;
    #1 reset = 1'b0;
    hist = 4'd0;
    mcnt = 8'd0;
    #1;
    check("rst_det", {7'd0, detector_out}, 8'd0);
    for (int i = 0; i < 3; i++) step(1'(i[0]));
    check("rst_hold_det", {7'd0, detector_out}, 8'd0);
    reset = 1'b1;

    // Single match then a trailing 1,1 that must not pulse
    feed(16'b0000, 4);
    feed(16'b101100110, 9);
    // Overlap
    feed(16'b1011011, 7);
    // Non-matching streams
    feed(16'b0010011, 7);
    feed(16'b001111, 6);
    feed(16'b00101010, 8);
    // Pulse then async reset while high
    feed(16'b1011, 4);
    async_reset();
    step(1'b1);
    reset = 1'b1;

    // Pattern split across reset is discarded
    feed(16'b00101, 5);
    async_reset();
    step(1'b1);
    reset = 1'b1;
    step(1'b1);
    feed(16'b011, 3);

    // 256 overlapping matches wrap the counter
    async_reset();
    step(1'b0);
    reset = 1'b1;
    feed(16'b1011, 4);
    for (int i = 0; i < 255; i++) feed(16'b011, 3);
    check("wrap_det", {7'd0, detector_out}, 8'd1);
`ifdef SD_MOORE_COUNT_EN
    check("wrap_cnt", detect_count, 8'd0);
`endif

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        async_reset();
        step(1'($urandom_range(0, 1)));
        reset = 1'b1;
      end
      step(1'($urandom_range(0, 1)));
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clock);
      guard++;
    end
    if (q.size() > 0) check("drain", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
